// File: rtl/io_pad_oe_sequencer.sv
// ---------------------------------------------------------------------------
// io_pad_oe_sequencer
//
// Staggered output-enable sequencer for the I/O pad ring. Pad driver groups
// are switched on one at a time (lowest index first) and off one at a time
// (highest index first), separated by a programmable idle interval, so the
// simultaneous switching current on the shared pad supply bond pads stays
// bounded.
//
// Parameters:
//   NGROUPS     number of pad driver groups (1..32)
//   STAGGER_W   width of the stagger interval field
//
// Ports:
//   clk          sequencer clock
//   rst_n        asynchronous active-low reset
//   force_off    (only with PAD_SEQ_FORCE_OFF_EN) emergency all-off
//   en_req       level request: 1 = enable unmasked groups, 0 = disable all
//   grp_mask     groups taking part; captured when leaving OFF
//   stagger_cfg  idle cycles between steps; captured when leaving OFF
//   oe_grp       registered per-group output enables
//   busy         high while ramping up or down
//   done         high while fully on
//
// Optional feature macro: PAD_SEQ_FORCE_OFF_EN (adds the force_off input).
// ---------------------------------------------------------------------------
module io_pad_oe_sequencer #(
    parameter int NGROUPS   = 8,
    parameter int STAGGER_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef PAD_SEQ_FORCE_OFF_EN
    input  logic                 force_off,
`endif
    input  logic                 en_req,
    input  logic [NGROUPS-1:0]   grp_mask,
    input  logic [STAGGER_W-1:0] stagger_cfg,
    output logic [NGROUPS-1:0]   oe_grp,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_RAMP_UP = 2'd1,
        ST_ON      = 2'd2,
        ST_RAMP_DN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NGROUPS-1:0]   oe_q, oe_d;
    logic [NGROUPS-1:0]   mask_q, mask_d;
    logic [STAGGER_W-1:0] stag_q, stag_d;
    logic [STAGGER_W-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [NGROUPS-1:0]   pend;
    logic [NGROUPS-1:0]   pick;

    // Isolate the lowest set bit (two's complement trick).
    function automatic logic [NGROUPS-1:0] lowest_bit(input logic [NGROUPS-1:0] v);
        logic [NGROUPS-1:0] one;
        one = {{(NGROUPS-1){1'b0}}, 1'b1};
        return v & (~v + one);
    endfunction

    // Isolate the highest set bit; later (higher) indices overwrite earlier.
    function automatic logic [NGROUPS-1:0] highest_bit(input logic [NGROUPS-1:0] v);
        logic [NGROUPS-1:0] r;
        r = '0;
        for (int i = 0; i < NGROUPS; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        oe_d    = oe_q;
        mask_d  = mask_q;
        stag_d  = stag_q;
        cnt_d   = cnt_q;
        pend    = '0;
        pick    = '0;

        case (state_q)
            ST_OFF: begin
                if (en_req) begin
                    state_d = ST_RAMP_UP;
                    mask_d  = grp_mask;
                    stag_d  = stagger_cfg;
                    cnt_d   = '0;
                end
            end
            ST_RAMP_UP: begin
                // A falling request wins over a pending step: no enable on
                // the reversal edge.
                if (!en_req) begin
                    state_d = ST_RAMP_DN;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    pend  = mask_q & ~oe_q;
                    pick  = lowest_bit(pend);
                    oe_d  = oe_q | pick;
                    cnt_d = stag_q;
                    // Last pending group (or nothing left) finishes the ramp.
                    if ((pend & ~pick) == '0) begin
                        state_d = ST_ON;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ON: begin
                if (!en_req) begin
                    state_d = ST_RAMP_DN;
                    cnt_d   = '0;
                end
            end
            ST_RAMP_DN: begin
                if (en_req) begin
                    state_d = ST_RAMP_UP;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    pick  = highest_bit(oe_q);
                    oe_d  = oe_q & ~pick;
                    cnt_d = stag_q;
                    if (oe_d == '0) begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
                oe_d    = '0;
                cnt_d   = '0;
            end
        endcase

`ifdef PAD_SEQ_FORCE_OFF_EN
        // Emergency path overrides everything, including a high en_req.
        if (force_off) begin
            state_d = ST_OFF;
            oe_d    = '0;
            cnt_d   = '0;
        end
`endif

        busy_d = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DN);
        done_d = (state_d == ST_ON);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            oe_q    <= '0;
            mask_q  <= '0;
            stag_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            oe_q    <= oe_d;
            mask_q  <= mask_d;
            stag_q  <= stag_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oe_grp = oe_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_io_pad_oe_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for io_pad_oe_sequencer. The reference model tracks how many of
// the latched mask's groups are enabled (always a prefix of the mask's set
// bits in ascending order) plus a wait countdown, and derives the expected
// outputs from that. Directed ramps pin exact edge timing with literals;
// a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_io_pad_oe_sequencer;
    localparam int NG = 8;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en_req = 1'b0;
    logic [NG-1:0] grp_mask = '0;
    logic [SW-1:0] stagger_cfg = '0;
    logic [NG-1:0] oe_grp;
    logic          busy;
    logic          done;
`ifdef PAD_SEQ_FORCE_OFF_EN
    logic          force_off = 1'b0;
`endif

    io_pad_oe_sequencer #(.NGROUPS(NG), .STAGGER_W(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef PAD_SEQ_FORCE_OFF_EN
        .force_off   (force_off),
`endif
        .en_req      (en_req),
        .grp_mask    (grp_mask),
        .stagger_cfg (stagger_cfg),
        .oe_grp      (oe_grp),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model: mode 0=off 1=up 2=on 3=down
    int md = 0;
    int n = 0;
    int g = 0;
    int wt = 0;
    int s_l = 0;
    int lst[NG];

    function automatic logic [NG-1:0] model_oe();
        logic [NG-1:0] r;
        r = '0;
        for (int j = 0; j < n; j++) r[lst[j]] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md = 0;
            n  = 0;
            wt = 0;
        end else begin
            case (md)
                0: if (en_req) begin
                    md = 1; wt = 0; s_l = int'(stagger_cfg); g = 0;
                    for (int i = 0; i < NG; i++)
                        if (grp_mask[i]) begin lst[g] = i; g++; end
                end
                1: if (!en_req) begin md = 3; wt = 0; end
                   else if (wt == 0) begin
                       if (n < g) n++;
                       if (n >= g) md = 2;
                       wt = s_l;
                   end else wt--;
                2: if (!en_req) begin md = 3; wt = 0; end
                default: if (en_req) begin md = 1; wt = 0; end
                   else if (wt == 0) begin
                       if (n > 0) n--;
                       if (n == 0) md = 0;
                       wt = s_l;
                   end else wt--;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (oe_grp !== model_oe() || busy !== (md == 1 || md == 3) || done !== (md == 2)) begin
                miscompares++;
                $display("FAIL cycle t=%0t: oe=%h busy=%b done=%b, expected oe=%h busy=%b done=%b",
                         $time, oe_grp, busy, done, model_oe(), (md == 1 || md == 3), (md == 2));
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance to n posedges from now, then step 1 time unit past the edge.
    task automatic adv(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drop_and_wait(input int k);
        @(negedge clk);
        en_req = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        grp_mask = 8'hFF;
        stagger_cfg = 8'd3;
        repeat (3) @(negedge clk);
        chk("reset_oe", {24'd0, oe_grp}, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'h0);
        chk("reset_done", {31'd0, done}, 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Full ramp up, M=FF, S=3: k is the edge sampling en_req.
        en_req = 1'b1;
        adv(2);  chk("up_first", {22'd0, busy, done, oe_grp}, {22'd0, 2'b10, 8'h01});
        adv(4);  chk("up_second", {24'd0, oe_grp}, 32'h03);
        adv(23); chk("up_k28", {22'd0, busy, done, oe_grp}, {22'd0, 2'b10, 8'h7F});
        adv(1);  chk("up_done", {22'd0, busy, done, oe_grp}, {22'd0, 2'b01, 8'hFF});
        repeat (10) @(negedge clk);

        // Ramp down mirrors it.
        en_req = 1'b0;
        adv(2);  chk("dn_first", {22'd0, busy, done, oe_grp}, {22'd0, 2'b10, 8'h7F});
        adv(27); chk("dn_k28", {22'd0, busy, done, oe_grp}, {22'd0, 2'b10, 8'h01});
        adv(1);  chk("dn_off", {22'd0, busy, done, oe_grp}, {22'd0, 2'b00, 8'h00});
        repeat (3) @(negedge clk);

        // Sparse mask, S=0: one group per edge.
        grp_mask = 8'b1010_0101;
        stagger_cfg = 8'd0;
        @(negedge clk);
        en_req = 1'b1;
        adv(2); chk("sparse_1", {24'd0, oe_grp}, 32'h01);
        adv(1); chk("sparse_2", {24'd0, oe_grp}, 32'h05);
        adv(1); chk("sparse_3", {24'd0, oe_grp}, 32'h25);
        adv(1); chk("sparse_4", {22'd0, busy, done, oe_grp}, {22'd0, 2'b01, 8'hA5});
        drop_and_wait(10);

        // Maximum stagger: spacing 256 cycles.
        grp_mask = 8'h03;
        stagger_cfg = 8'hFF;
        @(negedge clk);
        en_req = 1'b1;
        adv(2);   chk("smax_1", {24'd0, oe_grp}, 32'h01);
        adv(255); chk("smax_hold", {22'd0, busy, done, oe_grp}, {22'd0, 2'b10, 8'h01});
        adv(1);   chk("smax_2", {22'd0, busy, done, oe_grp}, {22'd0, 2'b01, 8'h03});
        drop_and_wait(300);

        // Reversal then re-rise, S=2.
        grp_mask = 8'hFF;
        stagger_cfg = 8'd2;
        @(negedge clk);
        en_req = 1'b1;
        adv(8);  chk("rev_up3", {24'd0, oe_grp}, 32'h07);
        @(negedge clk);
        en_req = 1'b0;
        adv(1);  chk("rev_noenable", {22'd0, busy, done, oe_grp}, {22'd0, 2'b10, 8'h07});
        adv(1);  chk("rev_clear2", {24'd0, oe_grp}, 32'h03);
        adv(3);  chk("rev_clear1", {24'd0, oe_grp}, 32'h01);
        @(negedge clk);
        en_req = 1'b1;
        adv(2);  chk("rev_resume", {24'd0, oe_grp}, 32'h03);
        adv(3);  chk("rev_resume2", {24'd0, oe_grp}, 32'h07);

        // Asynchronous reset mid-ramp, no clock edge needed.
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {22'd0, busy, done, oe_grp}, 32'h0);
        grp_mask = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        adv(2);  chk("mask0_done", {22'd0, busy, done, oe_grp}, {22'd0, 2'b01, 8'h00});
        drop_and_wait(4);

        // Randomized phase.
        for (int it = 0; it < 4000; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) en_req = ~en_req;
            if ($urandom_range(0, 7) == 0) grp_mask = NG'($urandom);
            if ($urandom_range(0, 7) == 0)
                stagger_cfg = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(0, 20))
                                                          : SW'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
